// File: rtl/logic_pkg.sv
// Shared constants for the pipelined logic unit.
// Holds the gate-function encodings and the unit gate delay.
`timescale 1ns/1ps
package logic_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_PASS = 3'd6;
  localparam logic [2:0] OP_NOT  = 3'd7;

  localparam int UNIT_DELAY = 1;

endpackage

// File: rtl/logic_pipe_stage.sv
// One elastic register stage: holds {valid, data}.
// Ports: up_valid/up_data in, down_adv from successor,
// valid/data out, adv = stage loads this cycle.
`timescale 1ns/1ps
module logic_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_adv,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             adv
);

  // An empty stage can always load, so bubbles collapse.
  assign adv = !valid || down_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (adv) begin
      valid <= up_valid;
      if (up_valid)
        data <= up_data;
    end
  end

endmodule

// File: rtl/logic_pipe_unit.sv
// Pipelined NIN-input bitwise logic unit with valid/ready flow.
// Ports: clk, rst (async high), in_valid/in_ready/op/in_data,
// out_valid/out_ready/out/out_zero, occupancy.
// Macro GATE_DELAY_EN: unit delay on the stage-0 reduction.
`timescale 1ns/1ps
module logic_pipe_unit
  import logic_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NIN    = 2,
  parameter int STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   op,
  input  logic [NIN*WIDTH-1:0]         in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out,
  output logic                         out_zero,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int OW = $clog2(STAGES+1);

  logic [WIDTH-1:0] w0;
  logic [WIDTH-1:0] red_and;
  logic [WIDTH-1:0] red_or;
  logic [WIDTH-1:0] red_xor;
  logic [WIDTH-1:0] red;
  logic [WIDTH-1:0] red_d;
  logic             acc;
  logic             drn;

  assign w0 = in_data[WIDTH-1:0];

  // Full-width reductions; inverted ops negate the
  // whole reduction, not a chain of 2-input gates.
  always_comb begin
    red_and = w0;
    red_or  = w0;
    red_xor = w0;
    for (int k = 1; k < NIN; k++) begin
      red_and = red_and & in_data[k*WIDTH +: WIDTH];
      red_or  = red_or  | in_data[k*WIDTH +: WIDTH];
      red_xor = red_xor ^ in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    red = '0;
    unique case (op)
      OP_AND:  red = red_and;
      OP_OR:   red = red_or;
      OP_XOR:  red = red_xor;
      OP_NAND: red = ~red_and;
      OP_NOR:  red = ~red_or;
      OP_XNOR: red = ~red_xor;
      OP_PASS: red = w0;
      OP_NOT:  red = ~w0;
    endcase
  end

`ifdef GATE_DELAY_EN
  assign #(UNIT_DELAY) red_d = red;
`else
  assign red_d = red;
`endif

  // Per-stage nets live in each generate block so the
  // advance chain is not one self-referencing vector.
  for (genvar i = 0; i < STAGES; i++) begin : g_st
    logic             v_l;
    logic [WIDTH-1:0] d_l;
    logic             adv_l;
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    logic             dn_adv;

    if (i == 0) begin : g_head
      assign up_v = in_valid;
      assign up_d = red_d;
    end else begin : g_body
      assign up_v = g_st[i-1].v_l;
      assign up_d = g_st[i-1].d_l;
    end

    if (i == STAGES-1) begin : g_tail
      assign dn_adv = out_ready;
    end else begin : g_mid
      assign dn_adv = g_st[i+1].adv_l;
    end

    logic_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (up_v),
      .up_data  (up_d),
      .down_adv (dn_adv),
      .valid    (v_l),
      .data     (d_l),
      .adv      (adv_l)
    );
  end

  assign in_ready  = g_st[0].adv_l;
  assign out_valid = g_st[STAGES-1].v_l;
  assign out       = g_st[STAGES-1].d_l;
  assign out_zero  = out_valid && (out == '0);

  assign acc = in_valid && in_ready;
  assign drn = out_valid && out_ready;

  // Items only enter at stage 0 and leave at the last
  // stage, so a +/- counter tracks the valid-bit count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      occupancy <= '0;
    else if (acc && !drn)
      occupancy <= occupancy + OW'(1);
    else if (!acc && drn)
      occupancy <= occupancy - OW'(1);
  end

endmodule

// File: tb/tb_logic_pipe_unit.sv
// Scoreboard bench for logic_pipe_unit
// (WIDTH=8, NIN=3, STAGES=3).
`timescale 1ns/1ps
module tb_logic_pipe_unit;

  localparam int W  = 8;
  localparam int N  = 3;
  localparam int S  = 3;
  localparam int OW = $clog2(S+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [N*W-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out;
  logic          out_zero;
  logic [OW-1:0] occupancy;

  logic_pipe_unit #(
    .WIDTH  (W),
    .NIN    (N),
    .STAGES (S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_zero  (out_zero),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_out = 0;
  int n_block = 0;
  int acc_cyc = -1;
  int ov_cyc = -1;
  bit meas = 1'b0;
  bit done = 1'b0;
  logic [W-1:0] sb[$];
  logic [W-1:0] e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, obs, exp, $time);
    end
  endtask

  // Bit-count model: AND = all ones, OR = any, XOR = odd.
  function automatic logic [W-1:0] model(
    input logic [2:0] o, input logic [N*W-1:0] d);
    logic [W-1:0] a, r, x;
    int c;
    for (int b = 0; b < W; b++) begin
      c = 0;
      for (int k = 0; k < N; k++)
        c += int'(d[k*W+b]);
      a[b] = (c == N);
      r[b] = (c != 0);
      x[b] = c[0];
    end
    case (o)
      3'd0: model = a;
      3'd1: model = r;
      3'd2: model = x;
      3'd3: model = ~a;
      3'd4: model = ~r;
      3'd5: model = ~x;
      3'd6: model = d[W-1:0];
      default: model = ~d[W-1:0];
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("out", 32'(out), 32'(e));
          chk("out_zero", 32'(out_zero), 32'(e == '0));
        end
        n_out++;
      end
      if (meas && ov_cyc < 0 && out_valid)
        ov_cyc = cyc;
      if (in_valid && in_ready) begin
        sb.push_back(model(op, in_data));
        n_acc++;
        if (meas && acc_cyc < 0)
          acc_cyc = cyc + 1;
      end
      if (meas && in_valid && !in_ready)
        n_block++;
    end
  end

  task automatic send(input logic [2:0] o,
                      input logic [N*W-1:0] d);
    int k;
    op = o;
    in_data = d;
    in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200)
      chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  int base;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    op = '0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // ops sweep on F0, CC, AA
    for (int o = 0; o < 8; o++)
      send(3'(o), {8'hAA, 8'hCC, 8'hF0});
    drain();

    // out_zero
    send(3'd0, {8'hFF, 8'hF0, 8'h0F});
    send(3'd1, {8'h00, 8'hF0, 8'h0F});
    drain();

    // latency and throughput
    acc_cyc = -1;
    ov_cyc = -1;
    n_block = 0;
    base = n_out;
    meas = 1'b1;
    for (int i = 0; i < 10; i++)
      send(3'($urandom_range(0, 7)), 24'($urandom));
    drain();
    meas = 1'b0;
    chk("latency", 32'(ov_cyc - acc_cyc), 32'(S - 1));
    chk("burst_block", 32'(n_block), 32'd0);
    chk("burst_count", 32'(n_out - base), 32'd10);

    // backpressure
    out_ready = 1'b0;
    base = n_acc;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(3'($urandom_range(0, 7)), 24'($urandom));
      end
      begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        #1;
        chk("bp_accepted", 32'(n_acc - base), 32'(S));
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_occ", 32'(occupancy), 32'(S));
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_out", 32'(out), 32'(sb[0]));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_occ_end", 32'(occupancy), 32'd0);

    // random stall mix
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++)
          send(3'($urandom_range(0, 7)), 24'($urandom));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("mix_occ_end", 32'(occupancy), 32'd0);

    // mid-stream reset with 2 in flight
    out_ready = 1'b0;
    send(3'd1, 24'h123456);
    send(3'd2, 24'h654321);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_occ", 32'(occupancy), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_occ", 32'(occupancy), 32'd0);
    chk("mid_rst_out", 32'(out), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    acc_cyc = -1;
    ov_cyc = -1;
    meas = 1'b1;
    send(3'd5, 24'hA5C3F0);
    drain();
    meas = 1'b0;
    chk("post_rst_latency", 32'(ov_cyc - acc_cyc), 32'(S - 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    chk("watchdog", 32'd1, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
